aes192_key_sched_ctrl: RTL

- Sequencer that drives one external AES-192 key-expansion stage iteratively to build the full schedule of 13 x 128-bit round keys.
- The stage takes a 192-bit key state plus an rcon byte and returns the next 192-bit state a fixed DP_LATENCY cycles later.
- The controller loads the cipher key, issues 8 expansion iterations while stepping rcon, and captures each result into an internal 52-word store.
- It serves round keys to the cipher core through a registered read port.

---
 rtl/aes192_key_sched_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/aes192_key_sched_ctrl.sv
// aes192_key_sched_ctrl
//   Sequences an external AES-192 key-expansion stage to build the 13 round
//   keys (52 words) of a cipher key. The stage computes the next 192-bit
//   key state from the current state and an rcon byte, with a fixed latency
//   of DP_LATENCY edges. Round keys are served through a registered read port.
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   start       begin expansion of key_in (honoured only when idle)
//   key_in      cipher key, [191:160]=w0 ... [31:0]=w5
//   busy        controller not idle
//   done        one-cycle pulse when the schedule is complete
//   keys_valid  store holds a complete schedule
//   dp_valid    one-cycle issue strobe to the expansion stage
//   dp_in       current key state to the stage
//   dp_rcon     rcon byte for the current iteration
//   dp_out      next key state from the stage
//   rk_rd_idx   round-key index 0..12 (13..15 read as zero)
//   rk_rd_data  {w[4i],w[4i+1],w[4i+2],w[4i+3]}, one cycle after rk_rd_idx
//
// State  | Meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; schedule (if any) is readable
// ISSUE  | dp_valid strobe; stage samples dp_in/dp_rcon on the next edge
// WAIT   | counting down DP_LATENCY edges until dp_out is captured
// DONE   | one-cycle done pulse, keys_valid set on the way out

module aes192_key_sched_ctrl #(
  parameter int DP_LATENCY = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [191:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  output logic         dp_valid,
  output logic [191:0] dp_in,
  output logic [7:0]   dp_rcon,
  input  logic [191:0] dp_out,
  input  logic [3:0]   rk_rd_idx,
  output logic [127:0] rk_rd_data
);

  localparam logic [3:0] LAT       = 4'(DP_LATENCY);
  localparam logic [3:0] LAST_ITER = 4'd8;
  localparam int         N_WORDS   = 52;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [191:0]   kstate_q, kstate_d;
  logic [7:0]     rcon_q, rcon_d;
  logic [3:0]     iter_q, iter_d;
  logic [3:0]     wcnt_q, wcnt_d;
  logic           kv_q, kv_d;
  logic           load_en;
  logic           cap_en;
  logic [6:0]     wbase;
  logic [31:0]    store_q [N_WORDS];
  logic [127:0]   rd_q;

  // General GF(2^8) doubling; the reduction never triggers within 8 rounds.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      kstate_q <= '0;
      rcon_q   <= '0;
      iter_q   <= '0;
      wcnt_q   <= '0;
      kv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      kstate_q <= kstate_d;
      rcon_q   <= rcon_d;
      iter_q   <= iter_d;
      wcnt_q   <= wcnt_d;
      kv_q     <= kv_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    kstate_d = kstate_q;
    rcon_d   = rcon_q;
    iter_d   = iter_q;
    wcnt_d   = wcnt_q;
    kv_d     = kv_q;
    load_en  = 1'b0;
    cap_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load_en  = 1'b1;
          kstate_d = key_in;
          iter_d   = 4'd1;
          rcon_d   = 8'h01;
          kv_d     = 1'b0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wcnt_d  = LAT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wcnt_d = wcnt_q - 4'd1;
        // Capture on the edge that takes the counter from 1 to 0.
        if (wcnt_q == 4'd1) begin
          cap_en   = 1'b1;
          kstate_d = dp_out;
          if (iter_q == LAST_ITER) begin
            state_d = S_DONE;
          end else begin
            iter_d  = iter_q + 4'd1;
            rcon_d  = xtime(rcon_q);
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        kv_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // First word index written by the current iteration's capture.
  assign wbase = 7'(iter_q) * 7'd6;

  // Word store: the final iteration lands partly past w51 and those words
  // simply have no destination.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < N_WORDS; j++) begin
        store_q[j] <= '0;
      end
    end else if (load_en) begin
      for (int k = 0; k < 6; k++) begin
        store_q[k] <= key_in[191-32*k -: 32];
      end
    end else if (cap_en) begin
      for (int j = 0; j < N_WORDS; j++) begin
        for (int k = 0; k < 6; k++) begin
          if (wbase + 7'(k) == 7'(j)) begin
            store_q[j] <= dp_out[191-32*k -: 32];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= '0;
    end else if (rk_rd_idx < 4'd13) begin
      rd_q <= {store_q[{rk_rd_idx, 2'b00}], store_q[{rk_rd_idx, 2'b01}],
               store_q[{rk_rd_idx, 2'b10}], store_q[{rk_rd_idx, 2'b11}]};
    end else begin
      rd_q <= '0;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign dp_valid   = (state_q == S_ISSUE);
  assign keys_valid = kv_q;
  assign dp_in      = kstate_q;
  assign dp_rcon    = rcon_q;
  assign rk_rd_data = rd_q;

endmodule
